// File: rtl/ro_freq_counter.sv
// ro_freq_counter
//
// Measures the frequency of a divided ring-oscillator output by counting its
// rising edges over a programmable window of reference-clock cycles. The
// result is offered on a valid/ready handshake and held until accepted.
//
// Optional feature macro: PVTMON_MINMAX_EN
//   When defined, min_cnt/max_cnt track the smallest/largest result handed
//   off since reset (saturated results included).
//
// Ports:
//   clk        in   reference clock, sole clock domain
//   rst        in   synchronous active-high reset, aborts any measurement
//   osc_in     in   oscillator signal, asynchronous to clk
//   start      in   one-cycle measurement request, honoured only when idle
//   gate_len   in   window length in clk cycles, latched on accepted start
//   busy       out  high while gating or holding a result
//   cnt_data   out  edge count of the last window (saturating)
//   cnt_ovf    out  count saturated during the last window
//   cnt_valid  out  result available
//   cnt_ready  in   consumer accepts the result
//   min_cnt    out  [PVTMON_MINMAX_EN] minimum result since reset
//   max_cnt    out  [PVTMON_MINMAX_EN] maximum result since reset

module ro_freq_counter #(
  parameter int GATE_W      = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              cnt_ovf,
  output logic              cnt_valid,
  input  logic              cnt_ready
`ifdef PVTMON_MINMAX_EN
  ,
  output logic [CNT_W-1:0]  min_cnt,
  output logic [CNT_W-1:0]  max_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Synchronizer and rising-edge detect; runs in every state.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   osc_rise;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= 1'b0;
          else     sync_q[gi] <= osc_in;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= 1'b0;
          else     sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign osc_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // ---------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [GATE_W-1:0]  down_q, down_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    down_d  = down_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          ovf_d   = 1'b0;
          if (gate_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GATE;
            down_d  = gate_len;
          end
        end
      end
      S_GATE: begin
        if (osc_rise) begin
          // Hold at all-ones once full; flag the lost edge.
          if (count_q == '1) ovf_d   = 1'b1;
          else               count_d = count_q + CNT_W'(1);
        end
        down_d = down_q - GATE_W'(1);
        // down_q==1 marks the last gate cycle of the window.
        if (down_q == GATE_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        // start is deliberately not examined here, even on acceptance.
        if (cnt_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      down_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      down_q  <= down_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == S_GATE) || (state_q == S_DONE);
  assign cnt_valid = (state_q == S_DONE);
  assign cnt_data  = count_q;
  assign cnt_ovf   = ovf_q;

`ifdef PVTMON_MINMAX_EN
  // ---------------------------------------------------------------------
  // Running extremes, updated on every result handshake.
  // ---------------------------------------------------------------------
  logic             handshake;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  assign handshake = cnt_valid & cnt_ready;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (handshake) begin
      if (count_q < min_q) min_d = count_q;
      if (count_q > max_q) max_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_cnt = min_q;
  assign max_cnt = max_q;
`endif

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed testbench for ro_freq_counter. Instance A uses the default
// widths; instance B uses CNT_W=4 to reach saturation quickly. Both share
// the oscillator stimulus and reset.

module tb_ro_freq_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        osc;
  logic        start_a, start_b;
  logic        ready_a, ready_b;
  logic [15:0] gl_a, gl_b;

  logic        busy_a, ovf_a, valid_a;
  logic [15:0] data_a;
  logic        busy_b, ovf_b, valid_b;
  logic [3:0]  data_b;
`ifdef PVTMON_MINMAX_EN
  logic [15:0] min_a, max_a;
  logic [3:0]  min_b, max_b;
`endif

  int checks = 0;
  int errors = 0;
  int osc_half = 0;

  always #5 clk = ~clk;

  ro_freq_counter #(.GATE_W(16), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .osc_in    (osc),
    .start     (start_a),
    .gate_len  (gl_a),
    .busy      (busy_a),
    .cnt_data  (data_a),
    .cnt_ovf   (ovf_a),
    .cnt_valid (valid_a),
    .cnt_ready (ready_a)
`ifdef PVTMON_MINMAX_EN
    ,
    .min_cnt   (min_a),
    .max_cnt   (max_a)
`endif
  );

  ro_freq_counter #(.GATE_W(16), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .osc_in    (osc),
    .start     (start_b),
    .gate_len  (gl_b),
    .busy      (busy_b),
    .cnt_data  (data_b),
    .cnt_ovf   (ovf_b),
    .cnt_valid (valid_b),
    .cnt_ready (ready_b)
`ifdef PVTMON_MINMAX_EN
    ,
    .min_cnt   (min_b),
    .max_cnt   (max_b)
`endif
  );

  // Oscillator: toggles every osc_half clk cycles, offset from the clock edge.
  initial begin
    int c;
    c = 0;
    osc = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (osc_half != 0) begin
        c++;
        if (c >= osc_half) begin
          osc = ~osc;
          c = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns with the start edge (T) just passed.
  task automatic start_a_win(input logic [15:0] g);
    start_a = 1'b1;
    gl_a    = g;
    tick();
    start_a = 1'b0;
  endtask

  task automatic start_b_win(input logic [15:0] g);
    start_b = 1'b1;
    gl_b    = g;
    tick();
    start_b = 1'b0;
  endtask

  // n = number of clk edges after T until cnt_valid is seen high.
  task automatic wait_valid_a(output int n);
    n = 0;
    while (valid_a !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid_b(output int n);
    n = 0;
    while (valid_b !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic accept_a();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
  endtask

  task automatic accept_b();
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    gl_a = '0; gl_b = '0;
    repeat (3) tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_a); end
    checks++; if (data_a !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", data_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf_a); end
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %0b expected 0", valid_b); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int n;
    osc_half = 4;
    repeat (10) tick();
    start_a_win(16'd80);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy_a); end
    gl_a = 16'd5;  // must not affect the running window
    wait_valid_a(n);
    checks++; if (n != 80) begin errors++; $display("FAIL basic_latency: got %0d expected 80", n); end
    checks++; if (data_a !== 16'd10) begin errors++; $display("FAIL basic_data: got %0d expected 10", data_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %0b expected 0", ovf_a); end
    accept_a();
    checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL basic_release: got valid=%0b busy=%0b expected 0/0", valid_a, busy_a); end
    $display("test_basic: latency=%0d data=%0d", n, data_a);
  endtask

  task automatic test_saturation();
    int n;
    osc_half = 1;
    repeat (4) tick();
    start_b_win(16'd40);
    wait_valid_b(n);
    checks++; if (n != 40) begin errors++; $display("FAIL sat_latency: got %0d expected 40", n); end
    checks++; if (data_b !== 4'd15) begin errors++; $display("FAIL sat_data: got %0d expected 15", data_b); end
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %0b expected 1", ovf_b); end
    accept_b();
    start_b_win(16'd8);
    wait_valid_b(n);
    checks++; if (data_b !== 4'd4) begin errors++; $display("FAIL sat_next_data: got %0d expected 4", data_b); end
    checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL sat_next_ovf: got %0b expected 0", ovf_b); end
    accept_b();
    $display("test_saturation: second run data=%0d", data_b);
  endtask

  task automatic test_zero_len();
    osc_half = 4;
    ready_a = 1'b1;
    start_a_win(16'd0);
    checks++; if (valid_a !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL zero_valid: got valid=%0b busy=%0b expected 1/1", valid_a, busy_a); end
    checks++; if (data_a !== 16'd0 || ovf_a !== 1'b0) begin errors++; $display("FAIL zero_data: got data=%0d ovf=%0b expected 0/0", data_a, ovf_a); end
    tick();
    checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin errors++; $display("FAIL zero_busy_once: got busy=%0b valid=%0b expected 0/0", busy_a, valid_a); end
    ready_a = 1'b0;
    $display("test_zero_len done");
  endtask

  task automatic test_back_to_back();
    int n;
    osc_half = 4;
    start_a_win(16'd16);
    wait_valid_a(n);
    checks++; if (data_a !== 16'd2) begin errors++; $display("FAIL hold_first: got %0d expected 2", data_a); end
    for (int i = 0; i < 20; i++) begin
      start_a = 1'b1;
      gl_a = (i % 2 == 1) ? 16'd0 : 16'd8;
      tick();
      checks++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || data_a !== 16'd2) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%0b busy=%0b data=%0d expected 1/1/2", i, valid_a, busy_a, data_a);
      end
    end
    // start coinciding with acceptance must be ignored
    ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    ready_a = 1'b0;
    checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL hold_accept: got valid=%0b busy=%0b expected 0/0", valid_a, busy_a); end
    repeat (3) tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL hold_no_restart: got busy=%0b expected 0", busy_a); end
    $display("test_back_to_back done");
  endtask

  task automatic test_abort();
    int n;
    logic seen;
    osc_half = 4;
    start_a_win(16'd80);
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 16'd0 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: got busy=%0b valid=%0b data=%0d ovf=%0b expected all 0", busy_a, valid_a, data_a, ovf_a);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid_a === 1'b1 || busy_a === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result: got activity=%0b expected 0", seen); end
    start_a_win(16'd80);
    wait_valid_a(n);
    checks++; if (n != 80 || data_a !== 16'd10) begin errors++; $display("FAIL abort_fresh: got latency=%0d data=%0d expected 80/10", n, data_a); end
    accept_a();
    $display("test_abort: fresh data=%0d", data_a);
  endtask

`ifdef PVTMON_MINMAX_EN
  task automatic test_minmax();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (min_a !== 16'hFFFF || max_a !== 16'd0) begin errors++; $display("FAIL minmax_reset: got min=%0d max=%0d expected 65535/0", min_a, max_a); end
    osc_half = 4;
    start_a_win(16'd80); wait_valid_a(n); accept_a();
    start_a_win(16'd40); wait_valid_a(n); accept_a();
    start_a_win(16'd96); wait_valid_a(n);
    checks++; if (data_a !== 16'd12) begin errors++; $display("FAIL minmax_third: got %0d expected 12", data_a); end
    accept_a();
    checks++; if (min_a !== 16'd5) begin errors++; $display("FAIL minmax_min: got %0d expected 5", min_a); end
    checks++; if (max_a !== 16'd12) begin errors++; $display("FAIL minmax_max: got %0d expected 12", max_a); end
    $display("test_minmax: min=%0d max=%0d", min_a, max_a);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_zero_len();
    test_back_to_back();
    test_abort();
`ifdef PVTMON_MINMAX_EN
    test_minmax();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
